// File: rtl/ddr2_ring_controller.sv
// ddr2_ring_controller: moves bursts from the input mini-FIFO into an SDRAM ring through an MCB/MIG user port,
// then from the ring back to the output FIFO, with fill tracking, wrap-around and fair write/read arbitration.
// Ports: clk, reset (async, active high); writes_en/reads_en enables; calib_done; burst_len; ring_clear;
//   ib_re/ib_data/ib_count/ib_valid input FIFO; ob_we/ob_data/ob_count output FIFO;
//   p0_cmd_*, p0_wr_*, p0_rd_* MCB user port; wr_ptr/rd_ptr ring byte addresses; ram_words fill; overflow sticky.
// Option: define DDR_RING_STATUS_EN to make ram_words and overflow live; otherwise both read as 0.
module ddr2_ring_controller #(
   parameter int          DATA_W     = 32,
   parameter int          MAX_BURST  = 64,
   parameter int          OB_DEPTH   = 2048,
   parameter int          CNT_W      = 11,
   parameter logic [29:0] RING_BASE  = 30'h0,
   parameter int          RING_WORDS = 1 << 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                writes_en,
   input  logic                reads_en,
   input  logic                calib_done,
   input  logic [6:0]          burst_len,
   input  logic                ring_clear,
   output logic                ib_re,
   input  logic [DATA_W-1:0]   ib_data,
   input  logic [CNT_W-1:0]    ib_count,
   input  logic                ib_valid,
   output logic                ob_we,
   output logic [DATA_W-1:0]   ob_data,
   input  logic [CNT_W-1:0]    ob_count,
   output logic                p0_cmd_en,
   output logic [2:0]          p0_cmd_instr,
   output logic [29:0]         p0_cmd_byte_addr,
   output logic [5:0]          p0_cmd_bl,
   input  logic                p0_cmd_full,
   output logic                p0_wr_en,
   output logic [DATA_W-1:0]   p0_wr_data,
   output logic [DATA_W/8-1:0] p0_wr_mask,
   input  logic                p0_wr_full,
   output logic                p0_rd_en,
   input  logic [DATA_W-1:0]   p0_rd_data,
   input  logic                p0_rd_empty,
   output logic [29:0]         wr_ptr,
   output logic [29:0]         rd_ptr,
   output logic [24:0]         ram_words,
   output logic                overflow
);

   localparam int          BYTES    = DATA_W / 8;
   localparam logic [24:0] RW       = 25'(RING_WORDS);
   localparam logic [30:0] RING_END = 31'(RING_BASE) + 31'(RING_WORDS * BYTES);

   typedef enum logic [2:0] {
      IDLE, W_FETCH, W_WAIT, W_CMD, R_CMD, R_WAIT, R_PUSH
   } state_t;

   state_t              state_q;
   logic [6:0]          b_q, cnt_q;
   logic [29:0]         wr_ptr_q, rd_ptr_q;
   logic [24:0]         fill_q;
   logic                last_rd_q, wen_q, ren_q;
   logic                ib_re_q, wr_en_q, cmd_en_q, rd_en_q, ob_we_q;
   logic [DATA_W-1:0]   wr_data_q, ob_data_q;
   logic [2:0]          cmd_instr_q;
   logic [29:0]         cmd_addr_q;
   logic [5:0]          cmd_bl_q;

   logic [6:0]          eff_b;
   logic [24:0]         free_w;
   logic [31:0]         ob_need;
   logic                wr_elig, rd_elig, pick_w;
   logic [29:0]         wr_ptr_d, rd_ptr_d;

   // Step a ring pointer by one burst; landing on the ring end folds back to the base.
   function automatic logic [29:0] adv(input logic [29:0] p, input logic [6:0] b);
      logic [30:0] n;
      n = {1'b0, p} + 31'(b) * 31'(BYTES);
      return (n >= RING_END) ? RING_BASE : n[29:0];
   endfunction

   always_comb begin
      eff_b = burst_len;
      if (burst_len == 7'd0)
         eff_b = 7'd1;
      else if (32'(burst_len) > 32'(MAX_BURST))
         eff_b = 7'(MAX_BURST);
   end

   assign free_w   = RW - fill_q;
   assign ob_need  = 32'(ob_count) + 32'(eff_b) + 32'd1;
   assign wr_elig  = calib_done && wen_q
                   && (32'(ib_count) >= 32'(eff_b))
                   && (free_w >= 25'(eff_b));
   assign rd_elig  = calib_done && ren_q
                   && (fill_q >= 25'(eff_b))
                   && (ob_need < 32'(OB_DEPTH));
   // On a tie the path that was not served last takes the turn.
   assign pick_w   = wr_elig && (!rd_elig || last_rd_q);
   assign wr_ptr_d = adv(wr_ptr_q, b_q);
   assign rd_ptr_d = adv(rd_ptr_q, b_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         b_q         <= 7'd1;
         cnt_q       <= '0;
         wr_ptr_q    <= RING_BASE;
         rd_ptr_q    <= RING_BASE;
         fill_q      <= '0;
         last_rd_q   <= 1'b1;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         ib_re_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         cmd_en_q    <= 1'b0;
         rd_en_q     <= 1'b0;
         ob_we_q     <= 1'b0;
         wr_data_q   <= '0;
         ob_data_q   <= '0;
         cmd_instr_q <= '0;
         cmd_addr_q  <= '0;
         cmd_bl_q    <= '0;
      end else begin
         wen_q    <= writes_en;
         ren_q    <= reads_en;
         ib_re_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         cmd_en_q <= 1'b0;
         rd_en_q  <= 1'b0;
         ob_we_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ring_clear) begin
                  wr_ptr_q <= RING_BASE;
                  rd_ptr_q <= RING_BASE;
                  fill_q   <= '0;
               end else if (pick_w) begin
                  b_q       <= eff_b;
                  cnt_q     <= eff_b;
                  last_rd_q <= 1'b0;
                  ib_re_q   <= 1'b1;
                  state_q   <= W_FETCH;
               end else if (rd_elig) begin
                  b_q       <= eff_b;
                  cnt_q     <= eff_b;
                  last_rd_q <= 1'b1;
                  state_q   <= R_CMD;
               end
            end
            W_FETCH: state_q <= W_WAIT;
            W_WAIT: begin
               if (ib_valid && !p0_wr_full) begin
                  wr_data_q <= ib_data;
                  wr_en_q   <= 1'b1;
                  cnt_q     <= cnt_q - 7'd1;
                  if (cnt_q == 7'd1) begin
                     state_q <= W_CMD;
                  end else begin
                     ib_re_q <= 1'b1;
                     state_q <= W_FETCH;
                  end
               end
            end
            W_CMD: begin
               if (!p0_cmd_full) begin
                  cmd_en_q    <= 1'b1;
                  cmd_instr_q <= 3'b000;
                  cmd_addr_q  <= wr_ptr_q;
                  cmd_bl_q    <= 6'(b_q - 7'd1);
                  wr_ptr_q    <= wr_ptr_d;
                  fill_q      <= fill_q + 25'(b_q);
                  state_q     <= IDLE;
               end
            end
            R_CMD: begin
               if (!p0_cmd_full) begin
                  cmd_en_q    <= 1'b1;
                  cmd_instr_q <= 3'b001;
                  cmd_addr_q  <= rd_ptr_q;
                  cmd_bl_q    <= 6'(b_q - 7'd1);
                  rd_ptr_q    <= rd_ptr_d;
                  fill_q      <= fill_q - 25'(b_q);
                  state_q     <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (!p0_rd_empty) begin
                  rd_en_q <= 1'b1;
                  state_q <= R_PUSH;
               end
            end
            R_PUSH: begin
               ob_data_q <= p0_rd_data;
               ob_we_q   <= 1'b1;
               cnt_q     <= cnt_q - 7'd1;
               state_q   <= (cnt_q == 7'd1) ? IDLE : R_WAIT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ib_re            = ib_re_q;
   assign ob_we            = ob_we_q;
   assign ob_data          = ob_data_q;
   assign p0_cmd_en        = cmd_en_q;
   assign p0_cmd_instr     = cmd_instr_q;
   assign p0_cmd_byte_addr = cmd_addr_q;
   assign p0_cmd_bl        = cmd_bl_q;
   assign p0_wr_en         = wr_en_q;
   assign p0_wr_data       = wr_data_q;
   assign p0_wr_mask       = '0;
   assign p0_rd_en         = rd_en_q;
   assign wr_ptr           = wr_ptr_q;
   assign rd_ptr           = rd_ptr_q;

`ifdef DDR_RING_STATUS_EN
   logic ovf_q;
   logic ovf_hit;

   // Input FIFO saturated while the ring has no room for a burst.
   assign ovf_hit = calib_done && wen_q && (&ib_count)
                  && (free_w < 25'(eff_b));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_q <= 1'b0;
      else if (state_q == IDLE && ring_clear)
         ovf_q <= 1'b0;
      else if (ovf_hit)
         ovf_q <= 1'b1;
   end

   assign ram_words = fill_q;
   assign overflow  = ovf_q;
`else
   assign ram_words = '0;
   assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_ring_controller.sv
// tb_ddr2_ring_controller: directed bench with input FIFO, MCB and output scoreboard models.
// Ring of 128 words at byte 0x1000, DATA_W 32.
module tb_ddr2_ring_controller;

   localparam logic [29:0] BASE = 30'h1000;
`ifdef DDR_RING_STATUS_EN
   localparam bit ST = 1'b1;
`else
   localparam bit ST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        writes_en = 1'b0, reads_en = 1'b0, calib_done = 1'b0;
   logic [6:0]  burst_len = '0;
   logic        ring_clear = 1'b0;
   logic        ib_re;
   logic [31:0] ib_data;
   logic [10:0] ib_count = '0;
   logic        ib_valid;
   logic        ob_we;
   logic [31:0] ob_data;
   logic [10:0] ob_count = '0;
   logic        p0_cmd_en;
   logic [2:0]  p0_cmd_instr;
   logic [29:0] p0_cmd_byte_addr;
   logic [5:0]  p0_cmd_bl;
   logic        p0_cmd_full = 1'b0;
   logic        p0_wr_en;
   logic [31:0] p0_wr_data;
   logic [3:0]  p0_wr_mask;
   logic        p0_wr_full = 1'b0;
   logic        p0_rd_en;
   logic [31:0] p0_rd_data;
   logic        p0_rd_empty;
   logic [29:0] wr_ptr, rd_ptr;
   logic [24:0] ram_words;
   logic        overflow;

   ddr2_ring_controller #(
      .DATA_W(32), .MAX_BURST(64), .OB_DEPTH(2048), .CNT_W(11),
      .RING_BASE(BASE), .RING_WORDS(128)
   ) dut (
      .clk(clk), .reset(reset),
      .writes_en(writes_en), .reads_en(reads_en),
      .calib_done(calib_done), .burst_len(burst_len),
      .ring_clear(ring_clear),
      .ib_re(ib_re), .ib_data(ib_data),
      .ib_count(ib_count), .ib_valid(ib_valid),
      .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
      .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
      .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
      .p0_cmd_full(p0_cmd_full),
      .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
      .p0_wr_mask(p0_wr_mask), .p0_wr_full(p0_wr_full),
      .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
      .p0_rd_empty(p0_rd_empty),
      .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
      .ram_words(ram_words), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ins;
      logic [29:0] adr;
      logic [5:0]  bl;
      logic [29:0] wp;
      logic [29:0] rp;
      logic [24:0] rw;
      int          cyc;
   } cmd_t;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          ob_cnt = 0;
   cmd_t        cmdq[$];
   int          ibre_q[$];
   logic [31:0] expq[$];
   logic [31:0] wq[$];
   logic [31:0] rdq[$];
   logic [31:0] mem [logic [29:0]];
   logic [31:0] nw = 32'hA000_0000;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cmds(input int n, input int budget);
      int k = 0;
      while (cmdq.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk($sformatf("cmd_wait%0d", n), 64'(cmdq.size()), 64'(n));
   endtask

   task automatic chk_cmd(input int i, input logic [2:0] ins,
                          input logic [29:0] adr, input logic [5:0] bl,
                          input logic [29:0] wp, input logic [29:0] rp,
                          input logic [24:0] rw);
      if (i >= cmdq.size()) return;
      chk($sformatf("c%0d_instr", i), 64'(cmdq[i].ins), 64'(ins));
      chk($sformatf("c%0d_addr", i), 64'(cmdq[i].adr), 64'(adr));
      chk($sformatf("c%0d_bl", i), 64'(cmdq[i].bl), 64'(bl));
      chk($sformatf("c%0d_wptr", i), 64'(cmdq[i].wp), 64'(wp));
      chk($sformatf("c%0d_rptr", i), 64'(cmdq[i].rp), 64'(rp));
      chk($sformatf("c%0d_words", i), 64'(cmdq[i].rw), 64'(rw));
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (expq.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain", 64'(expq.size()), 64'd0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Input FIFO: one-cycle read latency, sequential data words.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ib_valid <= 1'b0;
         ib_data  <= '0;
         expq.delete();
      end else if (ib_re) begin
         ib_valid <= 1'b1;
         ib_data  <= nw;
         expq.push_back(nw);
         nw = nw + 32'd1;
      end else begin
         ib_valid <= 1'b0;
      end
   end

   // MCB user port: write FIFO, word memory and read FIFO.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wq.delete();
         rdq.delete();
         p0_rd_empty <= 1'b1;
         p0_rd_data  <= '0;
      end else begin
         if (p0_rd_en && rdq.size() > 0) void'(rdq.pop_front());
         if (p0_wr_en) wq.push_back(p0_wr_data);
         if (p0_cmd_en) begin
            for (int i = 0; i <= int'(p0_cmd_bl); i++) begin
               if (p0_cmd_instr == 3'b000) begin
                  if (wq.size() > 0)
                     mem[p0_cmd_byte_addr + 30'(4 * i)] = wq.pop_front();
               end else if (mem.exists(p0_cmd_byte_addr + 30'(4 * i))) begin
                  rdq.push_back(mem[p0_cmd_byte_addr + 30'(4 * i)]);
               end else begin
                  rdq.push_back(32'hDEAD_BEEF);
               end
            end
         end
         p0_rd_empty <= (rdq.size() == 0);
         p0_rd_data  <= (rdq.size() > 0) ? rdq[0] : 32'h0;
      end
   end

   // Observation: command log, pulse counts, output data in write order.
   always @(negedge clk) begin
      if (p0_cmd_en)
         cmdq.push_back('{p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl,
                          wr_ptr, rd_ptr, ram_words, cyc});
      if (p0_wr_en) wr_cnt++;
      if (ib_re) ibre_q.push_back(cyc);
      if (ob_we) begin
         ob_cnt++;
         if (expq.size() == 0)
            chk("ob_extra", 64'(expq.size()), 64'd1);
         else
            chk("ob_data", 64'(ob_data), 64'(expq.pop_front()));
      end
   end

   logic [255:0] outs;
   assign outs = {ib_re, ob_we, ob_data, p0_cmd_en, p0_cmd_instr,
                  p0_cmd_byte_addr, p0_cmd_bl, p0_wr_en, p0_wr_data,
                  p0_wr_mask, p0_rd_en, ram_words, overflow};

   initial begin
      int n0, w0, o0;
      tick();
      tick();
      chk("rst_outs", 64'(|outs), 64'd0);
      chk("rst_wptr", 64'(wr_ptr), 64'(BASE));
      chk("rst_rptr", 64'(rd_ptr), 64'(BASE));
      reset = 1'b0;
      tick();

      // Single write burst, B=4.
      calib_done = 1'b1;
      burst_len  = 7'd4;
      ib_count   = 11'd4;
      writes_en  = 1'b1;
      wait_cmds(1, 60);
      ib_count  = '0;
      writes_en = 1'b0;
      chk("w1_pulses", 64'(wr_cnt), 64'd4);
      chk_cmd(0, 3'b000, BASE, 6'd3, BASE + 30'h10, BASE,
              ST ? 25'd4 : 25'd0);
      if (cmdq.size() > 0 && ibre_q.size() > 0)
         chk("w1_lat", 64'(cmdq[0].cyc - ibre_q[0]), 64'd9);

      // Read it back.
      reads_en = 1'b1;
      wait_cmds(2, 40);
      reads_en = 1'b0;
      chk_cmd(1, 3'b001, BASE, 6'd3, BASE + 30'h10, BASE + 30'h10, 25'd0);
      wait_drain(60);
      chk("r1_obwe", 64'(ob_cnt), 64'd4);

      // Both paths competing: W W R W R.
      ib_count  = 11'd100;
      writes_en = 1'b1;
      wait_cmds(3, 60);
      reads_en = 1'b1;
      wait_cmds(7, 200);
      writes_en = 1'b0;
      reads_en  = 1'b0;
      ib_count  = '0;
      chk_cmd(3, 3'b000, BASE + 30'h20, 6'd3, BASE + 30'h30, BASE + 30'h10,
              ST ? 25'd8 : 25'd0);
      chk_cmd(4, 3'b001, BASE + 30'h10, 6'd3, BASE + 30'h30, BASE + 30'h20,
              ST ? 25'd4 : 25'd0);
      chk_cmd(5, 3'b000, BASE + 30'h30, 6'd3, BASE + 30'h40, BASE + 30'h20,
              ST ? 25'd8 : 25'd0);
      chk_cmd(6, 3'b001, BASE + 30'h20, 6'd3, BASE + 30'h40, BASE + 30'h30,
              ST ? 25'd4 : 25'd0);
      tick();
      reads_en = 1'b1;
      wait_cmds(8, 200);
      reads_en = 1'b0;
      chk_cmd(7, 3'b001, BASE + 30'h30, 6'd3, BASE + 30'h40, BASE + 30'h40,
              25'd0);
      wait_drain(100);

      // Clear, then fill the ring with two 64-word bursts.
      ring_clear = 1'b1;
      tick();
      ring_clear = 1'b0;
      chk("clr_wptr", 64'(wr_ptr), 64'(BASE));
      chk("clr_rptr", 64'(rd_ptr), 64'(BASE));
      burst_len = 7'd100;
      ib_count  = 11'd200;
      writes_en = 1'b1;
      wait_cmds(10, 400);
      chk_cmd(8, 3'b000, BASE, 6'd63, BASE + 30'h100, BASE,
              ST ? 25'd64 : 25'd0);
      chk_cmd(9, 3'b000, BASE + 30'h100, 6'd63, BASE, BASE,
              ST ? 25'd128 : 25'd0);
      n0 = cmdq.size();
      repeat (150) tick();
      chk("full_block", 64'(cmdq.size()), 64'(n0));
      chk("ovf_low", 64'(overflow), 64'd0);
      ib_count = 11'd2047;
      tick();
      tick();
      chk("ovf_set", 64'(overflow), 64'(ST));
      ib_count  = '0;
      writes_en = 1'b0;
      repeat (3) tick();
      chk("ovf_sticky", 64'(overflow), 64'(ST));

      // Drain both bursts; read pointer wraps too.
      reads_en = 1'b1;
      wait_cmds(12, 400);
      reads_en = 1'b0;
      chk_cmd(10, 3'b001, BASE, 6'd63, BASE, BASE + 30'h100,
              ST ? 25'd64 : 25'd0);
      chk_cmd(11, 3'b001, BASE + 30'h100, 6'd63, BASE, BASE, 25'd0);
      wait_drain(300);
      ring_clear = 1'b1;
      tick();
      ring_clear = 1'b0;
      chk("ovf_clr", 64'(overflow), 64'd0);

      // burst_len 0 behaves as a single word.
      w0 = wr_cnt;
      burst_len = 7'd0;
      ib_count  = 11'd1;
      writes_en = 1'b1;
      wait_cmds(13, 40);
      ib_count  = '0;
      writes_en = 1'b0;
      chk("b1_pulses", 64'(wr_cnt - w0), 64'd1);
      chk_cmd(12, 3'b000, BASE, 6'd0, BASE + 30'h4, BASE,
              ST ? 25'd1 : 25'd0);
      repeat (3) tick();

      // Reset in W_WAIT with the command port stalled.
      n0 = cmdq.size();
      o0 = 0;
      burst_len   = 7'd4;
      ib_count    = 11'd4;
      p0_cmd_full = 1'b1;
      writes_en   = 1'b1;
      while (!ib_valid && o0 < 20) begin
         tick();
         o0++;
      end
      chk("wwait_seen", 64'(ib_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_outs", 64'(|outs), 64'd0);
      chk("mid_rst_wptr", 64'(wr_ptr), 64'(BASE));
      writes_en = 1'b0;
      ib_count  = '0;
      tick();
      chk("mid_rst_edge", 64'(|outs), 64'd0);
      w0 = wr_cnt;
      reset       = 1'b0;
      p0_cmd_full = 1'b0;
      repeat (20) tick();
      chk("mid_rst_nocmd", 64'(cmdq.size()), 64'(n0));
      chk("mid_rst_nowr", 64'(wr_cnt - w0), 64'd0);
      chk("mid_rst_rptr", 64'(rd_ptr), 64'(BASE));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
